// File: rtl/pipe_pkg.sv
// Shared IF/ID pipeline types: fill-state encoding, bubble encoding and the
// per-instruction payload carried from fetch to decode.
package pipe_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } fd_state_e;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] instruction;
    logic [XLEN_DEFAULT-1:0] pcsrc;
    logic [XLEN_DEFAULT-1:0] pc;
  } if_id_t;

  function automatic if_id_t bubble();
    if_id_t b;
    b.instruction = NOP_INSN_DEFAULT;
    b.pcsrc       = '0;
    b.pc          = '0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_decode_skid_register_skid_entry.sv
// One IF/ID holding slot: loads a new payload or returns to its clear value
// (the bubble), with clear taking priority.
module skid_entry #(
  parameter int unsigned    W         = 96,
  parameter logic [W-1:0]   CLEAR_VAL = '0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)      q_o <= CLEAR_VAL;
    else if (clear_i)  q_o <= CLEAR_VAL;
    else if (load_i)   q_o <= d_i;
  end

endmodule

// File: rtl/fetch_decode_skid_register.sv
// IF/ID register with valid/ready handshake, one-entry skid buffer, flush and
// a saturating decode-stall counter. Every output is driven straight from a flop.
module fetch_decode_skid_register
  import pipe_pkg::*;
#(
  parameter int unsigned     XLEN        = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSN    = XLEN'(NOP_INSN_DEFAULT),
  parameter int unsigned     STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   f_valid_i,
  output logic                   f_ready_o,
  input  logic [XLEN-1:0]        instruction_i,
  input  logic [XLEN-1:0]        pcsrc_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic                   flush_i,
  output logic                   fd_valid_o,
  input  logic                   d_ready_i,
  output logic [XLEN-1:0]        fd_instruction_o,
  output logic [XLEN-1:0]        fd_pcsrc_o,
  output logic [XLEN-1:0]        fd_pc_o,
  output logic [STALL_CNT_W-1:0] fd_stall_cnt_o
);

  localparam int unsigned     EW     = 3 * XLEN;
  localparam logic [EW-1:0]   BUBBLE = {NOP_INSN, {(2 * XLEN){1'b0}}};

  fd_state_e     state_q, state_d;
  logic          in_xfer, out_xfer;
  logic          main_load, main_clear, main_from_skid;
  logic          skid_load, skid_clear;
  logic [EW-1:0] in_data, main_d, main_q, skid_q;

  assign in_xfer  = f_valid_i & f_ready_o;
  assign out_xfer = fd_valid_o & d_ready_i;
  assign in_data  = {instruction_i, pcsrc_i, pc_i};
  assign main_d   = main_from_skid ? skid_q : in_data;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush_i) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (out_xfer) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
          end else if (in_xfer) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_d    = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // valid/ready are registered copies of the next-state decode so that no
  // output depends combinationally on the state register or any input.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= EMPTY;
      fd_valid_o <= 1'b0;
      f_ready_o  <= 1'b1;
    end else begin
      state_q    <= state_d;
      fd_valid_o <= (state_d != EMPTY);
      f_ready_o  <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)
      fd_stall_cnt_o <= '0;
    else if (fd_valid_o && !d_ready_i && (fd_stall_cnt_o != '1))
      fd_stall_cnt_o <= fd_stall_cnt_o + STALL_CNT_W'(1);
  end

  skid_entry #(
    .W         (EW),
    .CLEAR_VAL (BUBBLE)
  ) u_main (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (main_load),
    .clear_i (main_clear),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  skid_entry #(
    .W         (EW),
    .CLEAR_VAL (BUBBLE)
  ) u_skid (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .d_i     (in_data),
    .q_o     (skid_q)
  );

  assign {fd_instruction_o, fd_pcsrc_o, fd_pc_o} = main_q;

endmodule
